pkt_source: RTL and testbench
=============================

PKT_SOURCE -- requirements
Module: pkt_source

Interface
REQ-001 Parameter DATA_W, default 32, width of header and data words.
REQ-002 Parameter LEN_W, default 8, width of the beat-count request.
REQ-003 Parameter CNT_W, default 16, width of the sent-packet counter.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to send a packet; sampled only in IDLE.
REQ-007 hdr  input  DATA_W  header value for the requested packet.
REQ-008 len  input  LEN_W  number of data beats; 0 treated as 1.
REQ-009 seed  input  DATA_W  payload value of beat 0.
REQ-010 gap  input  4  idle cycles inserted after the last beat.
REQ-011 abort  input  1  terminate the current packet immediately.
REQ-012 hdr_in  output  DATA_W  packet header toward the filter's pkt_interface.
REQ-013 sop_in  output  1  start-of-packet, high on beat 0 only.
REQ-014 ena_in  output  1  beat valid.
REQ-015 data0_in  output  DATA_W  beat payload.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 done  output  1  one-cycle pulse on normal packet completion.
REQ-018 pkt_count  output  CNT_W  count of packets completed normally.

Function
REQ-019 FSM states IDLE, SEND, GAP; all outputs registered.
REQ-020 IDLE with start=1: latch hdr, len (0->1), seed, gap; go to SEND; beat 0 appears on outputs in the next cycle (1-cycle latency).
REQ-021 SEND: one beat per cycle, no stalls; beat k drives ena_in=1, data0_in=seed+k mod 2^DATA_W, sop_in=(k==0).
REQ-022 hdr_in holds the latched header for every beat of the packet; it is 0 outside SEND.
REQ-023 Beat counter is LEN_W+1 bits wide so len=2^LEN_W-1 completes without wrap; packet length is exactly max(len,1) beats.
REQ-024 After the last beat: gap>0 -> GAP for exactly gap cycles, then IDLE; gap=0 -> straight to IDLE.
REQ-025 done pulses for one cycle in the first IDLE cycle after a normal completion; pkt_count increments in that same cycle and wraps at 2^CNT_W.
REQ-026 ena_in, sop_in, data0_in are 0 in IDLE and GAP.
REQ-027 start outside IDLE is ignored; it is neither queued nor acknowledged.
REQ-028 start in the IDLE cycle that follows completion is accepted, giving back-to-back packets separated only by gap plus one IDLE cycle.
REQ-029 abort=1 in SEND or GAP returns to IDLE in the next cycle.
REQ-030 On abort, ena_in and sop_in are 0 from the next cycle, done does not pulse, and pkt_count does not change.
REQ-031 abort in IDLE has no effect; abort with start in IDLE discards the start.

Reset
REQ-032 rst=1 at a clock edge forces IDLE and clears the beat counter, latched fields and all outputs, including pkt_count.
REQ-033 rst has priority over start and abort; rst mid-packet truncates it with no done pulse.
REQ-034 The first start is accepted in the cycle after rst deasserts.

Verification
REQ-035 start, hdr=0xA5A5A5A5, len=3, seed=0x10, gap=2 -> next three cycles: ena=1, data 0x10/0x11/0x12, sop only on the first, hdr_in=0xA5A5A5A5 on all three; then 2 idle cycles; then done=1 and pkt_count=1.
REQ-036 len=0, seed=0xFFFFFFFF, gap=0 -> single beat with sop=1, ena=1, data=0xFFFFFFFF; done in the following cycle.
REQ-037 len=2, seed=0xFFFFFFFF -> data 0xFFFFFFFF then 0x00000000 (payload wrap).
REQ-038 start pulsed repeatedly during a len=4 packet -> exactly one packet of 4 beats is sent and pkt_count increments by 1.
REQ-039 abort on beat 2 of len=5 -> ena=0 from the next cycle, busy=0, no done, pkt_count unchanged; a following start sends a full packet.
REQ-040 rst asserted in GAP -> next cycle all outputs 0, pkt_count=0, busy=0.

Source files
------------

// File: rtl/pkt_source.sv
// Packet stimulus source: emits one header-tagged packet of incrementing payload
// beats per accepted start, followed by an optional idle gap.
module pkt_source #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] hdr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] seed,
    input  logic [3:0]        gap,
    input  logic              abort,
    output logic [DATA_W-1:0] hdr_in,
    output logic              sop_in,
    output logic              ena_in,
    output logic [DATA_W-1:0] data0_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pkt_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [LEN_W:0]    BEAT_ONE = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // A zero-length request still produces one beat; the extra MSB lets the
    // maximum request complete without the beat counter wrapping.
    function automatic logic [LEN_W:0] norm_len(input logic [LEN_W-1:0] l);
        return (l == '0) ? BEAT_ONE : {1'b0, l};
    endfunction

    state_t            state, state_nxt;
    logic [LEN_W:0]    beat, beat_nxt;
    logic [LEN_W:0]    len_q, len_nxt;
    logic [3:0]        gap_q, gap_nxt;
    logic [3:0]        gap_cnt, gap_cnt_nxt;
    logic [DATA_W-1:0] hdr_nxt, data_nxt;
    logic              sop_nxt, ena_nxt, busy_nxt, done_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    // Outputs are computed for the upcoming cycle so every port is a flop.
    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat;
        len_nxt     = len_q;
        gap_nxt     = gap_q;
        gap_cnt_nxt = gap_cnt;
        hdr_nxt     = '0;
        data_nxt    = '0;
        sop_nxt     = 1'b0;
        ena_nxt     = 1'b0;
        done_nxt    = 1'b0;
        cnt_nxt     = pkt_count;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = SEND;
                    beat_nxt  = '0;
                    len_nxt   = norm_len(len);
                    gap_nxt   = gap;
                    hdr_nxt   = hdr;
                    data_nxt  = seed;
                    sop_nxt   = 1'b1;
                    ena_nxt   = 1'b1;
                end
            end
            SEND: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if ((beat + BEAT_ONE) < len_q) begin
                    beat_nxt = beat + BEAT_ONE;
                    hdr_nxt  = hdr_in;
                    data_nxt = data0_in + DATA_ONE;
                    ena_nxt  = 1'b1;
                end else if (gap_q != 4'd0) begin
                    state_nxt   = GAP;
                    gap_cnt_nxt = gap_q;
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    cnt_nxt   = pkt_count + CNT_ONE;
                end
            end
            GAP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (gap_cnt == 4'd1) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    cnt_nxt   = pkt_count + CNT_ONE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            hdr_in    <= '0;
            data0_in  <= '0;
            sop_in    <= 1'b0;
            ena_in    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pkt_count <= '0;
        end else begin
            state     <= state_nxt;
            beat      <= beat_nxt;
            len_q     <= len_nxt;
            gap_q     <= gap_nxt;
            gap_cnt   <= gap_cnt_nxt;
            hdr_in    <= hdr_nxt;
            data0_in  <= data_nxt;
            sop_in    <= sop_nxt;
            ena_in    <= ena_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pkt_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pkt_source.sv
// Self-checking bench for pkt_source: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-of-expected-cycles reference model.
module tb_pkt_source;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst, start, abort;
    logic [DATA_W-1:0] hdr, seed;
    logic [LEN_W-1:0]  len;
    logic [3:0]        gap;
    logic [DATA_W-1:0] hdr_in, data0_in;
    logic              sop_in, ena_in, busy, done;
    logic [CNT_W-1:0]  pkt_count;

    pkt_source #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .hdr(hdr), .len(len), .seed(seed),
        .gap(gap), .abort(abort), .hdr_in(hdr_in), .sop_in(sop_in), .ena_in(ena_in),
        .data0_in(data0_in), .busy(busy), .done(done), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    // One expected output cycle.
    typedef struct packed {
        logic              busy;
        logic              ena;
        logic              sop;
        logic              done;
        logic [DATA_W-1:0] hdr;
        logic [DATA_W-1:0] data;
    } rec_t;

    rec_t             q[$];
    rec_t             cur;
    logic [CNT_W-1:0] mcnt;
    int               tests = 0;
    int               fails = 0;

    // A packet is the list of cycles it will occupy: beats, gap cycles, and the
    // completion cycle (which is already idle, so it may accept a new start).
    task automatic model_step();
        int   n;
        rec_t r;
        if (rst) begin
            q.delete();
            mcnt = '0;
            cur  = '0;
            return;
        end
        if (!cur.busy) begin
            if (start && !abort) begin
                n = (len == '0) ? 1 : int'(len);
                for (int k = 0; k < n; k++) begin
                    r = '0; r.busy = 1'b1; r.ena = 1'b1; r.sop = (k == 0);
                    r.hdr = hdr; r.data = seed + DATA_W'(k);
                    q.push_back(r);
                end
                for (int k = 0; k < int'(gap); k++) begin
                    r = '0; r.busy = 1'b1;
                    q.push_back(r);
                end
                r = '0; r.done = 1'b1;
                q.push_back(r);
            end
        end else if (abort) begin
            q.delete();
        end
        if (q.size() > 0) cur = q.pop_front();
        else cur = '0;
        if (cur.done) mcnt = mcnt + 1'b1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("busy",      DATA_W'(busy),      DATA_W'(cur.busy));
        chk("ena_in",    DATA_W'(ena_in),    DATA_W'(cur.ena));
        chk("sop_in",    DATA_W'(sop_in),    DATA_W'(cur.sop));
        chk("done",      DATA_W'(done),      DATA_W'(cur.done));
        chk("hdr_in",    hdr_in,             cur.hdr);
        chk("data0_in",  data0_in,           cur.data);
        chk("pkt_count", DATA_W'(pkt_count), DATA_W'(mcnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic pulse(input logic [DATA_W-1:0] h, input logic [LEN_W-1:0] l,
                         input logic [DATA_W-1:0] s, input logic [3:0] g);
        hdr = h; len = l; seed = s; gap = g; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        hdr = '0; len = '0; seed = '0; gap = '0;
        mcnt = '0; cur = '0;
        tick();
        tick();
        chk("reset_busy", DATA_W'(busy), 32'd0);
        chk("reset_count", DATA_W'(pkt_count), 32'd0);

        // First start is taken at the first edge with rst low.
        rst = 1'b0;
        pulse(32'hA5A5A5A5, 8'd3, 32'h10, 4'd2);
        chk("basic_b0_data", data0_in, 32'h10);
        chk("basic_b0_sop", DATA_W'(sop_in), 32'd1);
        tick();
        chk("basic_b1_data", data0_in, 32'h11);
        chk("basic_b1_sop", DATA_W'(sop_in), 32'd0);
        tick();
        chk("basic_b2_hdr", hdr_in, 32'hA5A5A5A5);
        tick();
        chk("basic_gap_ena", DATA_W'(ena_in), 32'd0);
        tick();
        tick();
        chk("basic_done", DATA_W'(done), 32'd1);
        chk("basic_count", DATA_W'(pkt_count), 32'd1);

        // Back-to-back start in the done cycle; len 0 means one beat.
        pulse(32'h1, 8'd0, 32'hFFFFFFFF, 4'd0);
        chk("len0_data", data0_in, 32'hFFFFFFFF);
        chk("len0_sop", DATA_W'(sop_in), 32'd1);
        tick();
        chk("len0_done", DATA_W'(done), 32'd1);

        pulse(32'h2, 8'd2, 32'hFFFFFFFF, 4'd0);
        tick();
        chk("wrap_data", data0_in, 32'h0);
        tick();
        chk("wrap_count", DATA_W'(pkt_count), 32'd3);

        // Starts while busy are ignored.
        pulse(32'h3, 8'd4, 32'h100, 4'd1);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hdr = 32'hDEAD0000 + i; len = 8'd9;
            tick();
        end
        start = 1'b0;
        tick();
        chk("ignore_start_count", DATA_W'(pkt_count), 32'd4);
        tick();
        chk("ignore_start_idle", DATA_W'(busy), 32'd0);

        // Abort on beat index 2 of a 5-beat packet.
        pulse(32'h5, 8'd5, 32'h200, 4'd3);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ena", DATA_W'(ena_in), 32'd0);
        chk("abort_busy", DATA_W'(busy), 32'd0);
        chk("abort_count", DATA_W'(pkt_count), 32'd4);
        pulse(32'h6, 8'd5, 32'h300, 4'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("after_abort_count", DATA_W'(pkt_count), 32'd5);

        // Abort together with start in IDLE discards the start.
        abort = 1'b1;
        pulse(32'h7, 8'd2, 32'h0, 4'd0);
        abort = 1'b0;
        chk("abort_start_busy", DATA_W'(busy), 32'd0);

        // Reset while in GAP.
        pulse(32'h8, 8'd1, 32'h55, 4'd5);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_gap_busy", DATA_W'(busy), 32'd0);
        chk("rst_gap_count", DATA_W'(pkt_count), 32'd0);
        chk("rst_gap_hdr", hdr_in, 32'd0);

        // Longest packet completes without counter wrap.
        pulse(32'h9, 8'd255, 32'hFFFFFF00, 4'd0);
        for (int i = 0; i < 255; i++) tick();
        chk("maxlen_done", DATA_W'(done), 32'd1);
        chk("maxlen_count", DATA_W'(pkt_count), 32'd1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            hdr   = $urandom;
            seed  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFE : $urandom;
            len   = LEN_W'($urandom_range(0, 7));
            gap   = 4'($urandom_range(0, 4));
            abort = ($urandom_range(0, 29) == 0);
            rst   = ($urandom_range(0, 249) == 0);
            tick();
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        for (int i = 0; i < 30; i++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
